sr_debounce_ctrl: RTL and testbench

//   Input-conditioning stage that sits directly upstream of SR_latch and drives its s/r inputs.
//   - Takes two raw, asynchronous push-button inputs: SET and RESET.
//   - Synchronises and debounces each one.
//   - Emits one-cycle s/r pulses on each debounced press.
//   - Never asserts s and r together (forbidden SR state); a simultaneous press is flagged instead.

---
 rtl/sr_debounce_ctrl_if.sv | 31 +++
 rtl/sr_debounce_ctrl.sv | 87 ++++++++
 tb/tb_sr_debounce_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sr_debounce_ctrl_if.sv
// Button/pulse bundle between raw push-buttons, the debouncer and SR_latch.
// The master drives the buttons; the slave (debouncer) drives the pulses and levels.
interface sr_debounce_ctrl_if;
  logic set_btn;
  logic rst_btn;
  logic s;
  logic r;
  logic set_lvl;
  logic rst_lvl;
  logic conflict;

  modport master (
    output set_btn,
    output rst_btn,
    input  s,
    input  r,
    input  set_lvl,
    input  rst_lvl,
    input  conflict
  );

  modport slave (
    input  set_btn,
    input  rst_btn,
    output s,
    output r,
    output set_lvl,
    output rst_lvl,
    output conflict
  );
endinterface

// File: rtl/sr_debounce_ctrl.sv
// Synchronise and debounce SET/RESET buttons, emit one-cycle s/r pulses.
// A simultaneous debounced press raises conflict instead of s and r.
module sr_debounce_ctrl #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 8
) (
  input logic            clk,
  input logic            reset,
  sr_debounce_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

  // bit 0 = SET channel, bit 1 = RESET channel
  logic [1:0]       raw;
  logic [1:0]       meta;
  logic [1:0]       sync;
  logic [1:0]       stable;
  logic [1:0]       stable_d;
  logic [1:0]       rise;
  logic [CNT_W-1:0] cnt [2];
  logic             s_q;
  logic             r_q;
  logic             conflict_q;

  assign raw  = {bus.rst_btn, bus.set_btn};
  assign rise = stable & ~stable_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta     <= '0;
      sync     <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      meta     <= raw;
      sync     <= meta;
      stable_d <= stable;
      // Any return to the stable value throws the partial count away.
      for (int i = 0; i < 2; i++) begin
        unique case (1'b1)
          (sync[i] == stable[i]): begin
            cnt[i] <= '0;
          end
          (sync[i] != stable[i]) && (cnt[i] == LAST): begin
            stable[i] <= sync[i];
            cnt[i]    <= '0;
          end
          (sync[i] != stable[i]) && (cnt[i] != LAST): begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      unique case (1'b1)
        (rise == 2'b11): begin
          s_q        <= 1'b0;
          r_q        <= 1'b0;
          conflict_q <= 1'b1;
        end
        (rise != 2'b11): begin
          s_q        <= rise[0];
          r_q        <= rise[1];
          conflict_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.conflict = conflict_q;
  assign bus.set_lvl  = stable[0];
  assign bus.rst_lvl  = stable[1];

endmodule

// File: tb/tb_sr_debounce_ctrl.sv
// Scoreboard bench for sr_debounce_ctrl with DEBOUNCE_CYC=4.
// Expected pulses are queued at stimulus time and matched on the negedge.
module tb_sr_debounce_ctrl;

  localparam int DEB = 4;
  localparam logic [2:0] EV_S = 3'b001;
  localparam logic [2:0] EV_R = 3'b010;
  localparam logic [2:0] EV_C = 3'b100;

  typedef struct packed {
    logic [2:0] kind;
    int         cyc;
  } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic q_latch = 1'b0;
  ev_t  sb[$];
  ev_t  ev;
  logic [2:0] obs;
  int   e0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_debounce_ctrl_if bus();

  sr_debounce_ctrl #(
    .DEBOUNCE_CYC(DEB),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // SR_latch stand-in driven by the pulses
  always @(posedge clk) begin
    if (bus.s) q_latch <= 1'b1;
    else if (bus.r) q_latch <= 1'b0;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(logic [2:0] k, int at);
    sb.push_back('{kind: k, cyc: at});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    obs = {bus.conflict, bus.r, bus.s};
    if (obs != 3'b000) begin
      chk("s_and_r", {31'd0, bus.s & bus.r}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexp_pulse", {29'd0, obs}, 32'd0);
      end else begin
        ev = sb.pop_front();
        chk("ev_kind", {29'd0, obs}, {29'd0, ev.kind});
        chk("ev_cyc", cyc, ev.cyc);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;
    @(negedge clk);
    chk("rst_outs", {27'd0, bus.s, bus.r, bus.set_lvl,
        bus.rst_lvl, bus.conflict}, 32'd0);
    tick(1);
    reset = 1'b1;
    tick(5);
    chk("idle_outs", {27'd0, bus.s, bus.r, bus.set_lvl,
        bus.rst_lvl, bus.conflict}, 32'd0);

    // clean SET press
    e0 = cyc;
    bus.set_btn = 1'b1;
    expect_ev(EV_S, e0 + 7);
    tick(5);
    chk("set_lvl_e5", {31'd0, bus.set_lvl}, 32'd0);
    tick(1);
    chk("set_lvl_e6", {31'd0, bus.set_lvl}, 32'd1);
    tick(14);
    chk("q_after_set", {31'd0, q_latch}, 32'd1);

    // RESET pressed while SET still held
    e0 = cyc;
    bus.rst_btn = 1'b1;
    expect_ev(EV_R, e0 + 7);
    tick(5);
    chk("rst_lvl_e5", {31'd0, bus.rst_lvl}, 32'd0);
    tick(1);
    chk("rst_lvl_e6", {31'd0, bus.rst_lvl}, 32'd1);
    chk("set_lvl_hold", {31'd0, bus.set_lvl}, 32'd1);
    tick(4);
    chk("q_after_rst", {31'd0, q_latch}, 32'd0);
    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;
    tick(10);
    chk("lvls_released", {30'd0, bus.rst_lvl, bus.set_lvl}, 32'd0);

    // short bounce on SET must be rejected
    bus.set_btn = 1'b1;
    tick(1);
    bus.set_btn = 1'b0;
    tick(1);
    bus.set_btn = 1'b1;
    tick(1);
    bus.set_btn = 1'b0;
    tick(12);
    chk("bounce_lvl", {31'd0, bus.set_lvl}, 32'd0);

    // simultaneous press
    e0 = cyc;
    bus.set_btn = 1'b1;
    bus.rst_btn = 1'b1;
    expect_ev(EV_C, e0 + 7);
    tick(10);
    chk("both_lvls", {30'd0, bus.rst_lvl, bus.set_lvl}, 32'd3);
    chk("q_conflict", {31'd0, q_latch}, 32'd0);
    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;
    tick(10);

    // reset mid-count while SET stays held
    bus.set_btn = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
    chk("midrst_lvl", {31'd0, bus.set_lvl}, 32'd0);
    tick(1);
    reset = 1'b1;
    e0 = cyc;
    expect_ev(EV_S, e0 + 7);
    tick(5);
    chk("requal_e5", {31'd0, bus.set_lvl}, 32'd0);
    tick(1);
    chk("requal_e6", {31'd0, bus.set_lvl}, 32'd1);
    tick(10);
    chk("q_requal", {31'd0, q_latch}, 32'd1);
    bus.set_btn = 1'b0;
    tick(10);

    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
